motor_arm_controller: RTL

Arming and failsafe sequencer that drives the enable and stop inputs of the motor emergency-stop gate in front of the four DShot outputs. It arms the motors only after a host request with zero throttle held for a minimum time. It supervises a host heartbeat and an external kill switch, and latches a stop with a fault cause until the host explicitly clears it. It sits in the PL between the PS-facing control registers and the DShot output path.

---
 rtl/motor_arm_pkg.sv | 19 +
 rtl/kill_debounce.sv | 73 +++++++
 rtl/motor_arm_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/motor_arm_pkg.sv
// motor_arm_pkg: shared types and constants for the motor arming sequencer.
// Holds the 2-bit state encoding seen on state_o and the fault cause codes
// reported on fault_o.

package motor_arm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        STOPPED  = 2'd3
    } arm_state_e;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_KILL      = 2'd1;
    localparam logic [1:0] FAULT_HB        = 2'd2;
    localparam logic [1:0] FAULT_ARM_ABORT = 2'd3;

endpackage

// File: rtl/kill_debounce.sv
// kill_debounce: brings the asynchronous kill switch into the clk_i domain
// through a 2-FF synchronizer and, when MOTOR_ARM_KILL_DEBOUNCE_EN is
// defined, accepts a new level only after it has been stable for
// DEBOUNCE_CYC consecutive cycles. Without the macro q_o is the
// synchronizer output.

module kill_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage synchronizer for the asynchronous switch input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MOTOR_ARM_KILL_DEBOUNCE_EN
    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYC + 1);
    // The level flips on the DEBOUNCE_CYC-th consecutive disagreeing cycle.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Count consecutive cycles where the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q >= LAST) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Stability counter and accepted level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign q_o = lvl_q;
`else
    // DEBOUNCE_CYC only matters when the filter is compiled in.
    if (DEBOUNCE_CYC == 0) begin : g_no_filter
    end

    assign q_o = sync2_q;
`endif

endmodule

// File: rtl/motor_arm_controller.sv
// motor_arm_controller: arming and failsafe sequencer for the motor
// emergency-stop gate. Arms only after a host request with zero throttle
// held for ARM_HOLD_CYC cycles, supervises the host heartbeat and the
// external kill switch, and latches a stop with its first cause until the
// host clears it. Optional macro MOTOR_ARM_KILL_DEBOUNCE_EN enables the
// kill switch debounce filter inside kill_debounce.

module motor_arm_controller
    import motor_arm_pkg::*;
#(
    parameter int unsigned HB_TIMEOUT_CYC = 10_000_000,
    parameter int unsigned ARM_HOLD_CYC   = 1_000_000,
    parameter int unsigned DEBOUNCE_CYC   = 1_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       arm_req_i,
    input  logic       disarm_req_i,
    input  logic       fault_clear_i,
    input  logic       heartbeat_i,
    input  logic       throttle_zero_i,
    input  logic       kill_i,
    output logic       enable_o,
    output logic       stop_o,
    output logic [1:0] state_o,
    output logic [1:0] fault_o
);

    localparam int unsigned     HB_W       = $clog2(HB_TIMEOUT_CYC + 1);
    localparam int unsigned     HOLD_W     = $clog2(ARM_HOLD_CYC + 1);
    localparam logic [HB_W-1:0] HB_MAX     = HB_W'(HB_TIMEOUT_CYC);
    // Loss is flagged as the count steps onto HB_TIMEOUT_CYC, so enable_o
    // drops HB_TIMEOUT_CYC + 1 cycles after the last heartbeat pulse.
    localparam logic [HB_W-1:0] HB_LOST_AT = HB_W'(HB_TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ARM_HOLD_CYC);

    arm_state_e        state_q;
    arm_state_e        state_d;
    logic [1:0]        fault_q;
    logic [1:0]        fault_d;
    logic              enable_q;
    logic              enable_d;
    logic              stop_q;
    logic              stop_d;
    logic [HB_W-1:0]   hb_cnt_q;
    logic [HB_W-1:0]   hb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              kill_q;
    logic              hb_lost;
    logic              hold_done;

    kill_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_kill_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (kill_i),
        .q_o    (kill_q)
    );

    // Heartbeat and arming-hold counters: both saturate, DISARMED holds them at 0.
    always_comb begin
        hb_cnt_d   = '0;
        hold_cnt_d = '0;
        if (state_q != DISARMED && !heartbeat_i) begin
            hb_cnt_d = (hb_cnt_q >= HB_MAX) ? HB_MAX : hb_cnt_q + HB_W'(1);
        end
        if (state_q == ARMING && throttle_zero_i) begin
            hold_cnt_d = (hold_cnt_q >= HOLD_MAX) ? HOLD_MAX : hold_cnt_q + HOLD_W'(1);
        end
    end

    assign hb_lost   = (state_q != DISARMED) && !heartbeat_i && (hb_cnt_q >= HB_LOST_AT);
    assign hold_done = (hold_cnt_q >= HOLD_MAX);

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hb_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            hb_cnt_q   <= hb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next state and fault cause; the fault is written only on entry to STOPPED.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            DISARMED: begin
                if (kill_q) begin
                    state_d = STOPPED;
                    fault_d = FAULT_KILL;
                end else if (arm_req_i && !disarm_req_i && throttle_zero_i) begin
                    state_d = ARMING;
                end
            end
            ARMING, ARMED: begin
                if (kill_q) begin
                    state_d = STOPPED;
                    fault_d = FAULT_KILL;
                end else if (hb_lost) begin
                    state_d = STOPPED;
                    fault_d = FAULT_HB;
                end else if (disarm_req_i) begin
                    state_d = DISARMED;
                end else if (state_q == ARMING) begin
                    if (!throttle_zero_i) begin
                        state_d = STOPPED;
                        fault_d = FAULT_ARM_ABORT;
                    end else if (hold_done) begin
                        state_d = ARMED;
                    end
                end
            end
            STOPPED: begin
                if (fault_clear_i && !kill_q && (hb_cnt_q < HB_MAX)) begin
                    state_d = DISARMED;
                    fault_d = FAULT_NONE;
                end
            end
            default: begin
                state_d = DISARMED;
                fault_d = FAULT_NONE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs are registered alongside it.
    always_comb begin
        enable_d = (state_d == ARMED);
        stop_d   = (state_d == STOPPED) || kill_q;
    end

    // State, fault and output registers; stop is asserted out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DISARMED;
            fault_q  <= FAULT_NONE;
            enable_q <= 1'b0;
            stop_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            enable_q <= enable_d;
            stop_q   <= stop_d;
        end
    end

    assign state_o  = state_q;
    assign fault_o  = fault_q;
    assign enable_o = enable_q;
    assign stop_o   = stop_q;

endmodule
